// File: rtl/tsf_pkg.sv
// Shared constants and state encoding for the TSF / TBTT blocks.
package tsf_pkg;

    localparam int TU_SHIFT      = 10;
    localparam int ALIGN_LATENCY = 56;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        WAIT  = 2'd2
    } tbtt_state_t;

endpackage

// File: rtl/tbtt_mod_calc.sv
// Sequential restoring divider returning dividend mod divisor.
// One load cycle on start, then one quotient bit per cycle; done pulses once.
module tbtt_mod_calc
    import tsf_pkg::*;
#(
    parameter int DIV_WIDTH = 64 - TU_SHIFT,
    parameter int BI_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [BI_WIDTH-1:0]  divisor,
    output logic                 done,
    output logic [BI_WIDTH-1:0]  remainder
);

    localparam int CW = $clog2(DIV_WIDTH + 1);

    logic [DIV_WIDTH-1:0] quo;
    logic [BI_WIDTH-1:0]  rem;
    logic [BI_WIDTH-1:0]  dvs;
    logic [CW-1:0]        cnt;
    logic                 running;
    logic [BI_WIDTH:0]    shifted;
    logic [BI_WIDTH:0]    diff;
    logic                 ge;

    always_comb begin
        shifted = {rem, quo[DIV_WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        ge      = shifted >= {1'b0, dvs};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                running <= 1'b0;
            end else if (start) begin
                quo     <= dividend;
                rem     <= '0;
                dvs     <= divisor;
                cnt     <= CW'(DIV_WIDTH);
                running <= 1'b1;
            end else if (running) begin
                rem <= ge ? diff[BI_WIDTH-1:0] : shifted[BI_WIDTH-1:0];
                quo <= {quo[DIV_WIDTH-2:0], 1'b0};
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign remainder = rem;

endmodule

// File: rtl/tbtt_scheduler.sv
// TBTT scheduler: aligns to the beacon grid of the TSF and emits TBTT pulses.
// Define TBTT_PRE_WARN_EN to build the pre-TBTT early-warning pulse.
module tbtt_scheduler
    import tsf_pkg::*;
#(
    parameter int TIMER_WIDTH = 64,
    parameter int BI_WIDTH    = 16,
    parameter int PRE_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [TIMER_WIDTH-1:0] tsf_runtime_val,
    input  logic                   tsf_pulse_1M,
    input  logic [BI_WIDTH-1:0]    beacon_interval_tu,
    input  logic [PRE_WIDTH-1:0]   pre_tbtt_us,
    input  logic                   tbtt_resync,
    output logic                   tbtt_pulse,
    output logic                   pre_tbtt_pulse,
    output logic [TIMER_WIDTH-1:0] next_tbtt,
    output logic [15:0]            tbtt_count,
    output logic                   tbtt_aligned,
    output logic                   tbtt_missed
);

    localparam int DW = TIMER_WIDTH - TU_SHIFT;

    tbtt_state_t            state;
    logic [BI_WIDTH-1:0]    bi_lat;
    logic [TIMER_WIDTH-1:0] tsf_snap;
    logic                   mod_start;
    logic                   mod_abort;
    logic                   mod_done;
    logic [BI_WIDTH-1:0]    mod_rem;

    logic [TIMER_WIDTH-1:0] bi_us;
    logic [TIMER_WIDTH-1:0] tsf_mod;
    logic [TIMER_WIDTH-1:0] aligned_next;
    logic [TIMER_WIDTH-1:0] next_plus;
    logic [TIMER_WIDTH-1:0] ahead;
    logic                   run_ok;
    logic                   wait_tick;
    logic                   jump;
    logic                   hit;
    logic                   align_entry;

    tbtt_mod_calc #(
        .DIV_WIDTH (DW),
        .BI_WIDTH  (BI_WIDTH)
    ) u_mod (
        .clk       (clk),
        .rst       (rst),
        .start     (mod_start),
        .abort     (mod_abort),
        .dividend  (tsf_snap[TIMER_WIDTH-1:TU_SHIFT]),
        .divisor   (bi_lat),
        .done      (mod_done),
        .remainder (mod_rem)
    );

    assign run_ok    = enable && (beacon_interval_tu != '0);
    assign bi_us     = TIMER_WIDTH'(bi_lat) << TU_SHIFT;
    assign tsf_mod   = (TIMER_WIDTH'(mod_rem) << TU_SHIFT)
                     | TIMER_WIDTH'(tsf_snap[TU_SHIFT-1:0]);
    assign aligned_next = tsf_snap - tsf_mod + bi_us;
    assign next_plus = next_tbtt + bi_us;
    assign ahead     = next_tbtt - tsf_runtime_val;
    assign hit       = tsf_runtime_val >= next_tbtt;
    assign wait_tick = (state == WAIT) && tsf_pulse_1M;

    // Backward test only makes sense while the TBTT is still ahead of us.
    assign jump = (tsf_runtime_val >= next_plus)
               || (!hit && (ahead > bi_us));

    assign align_entry = run_ok
                      && ((state == IDLE) || tbtt_resync || (wait_tick && jump));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bi_lat       <= '0;
            tsf_snap     <= '0;
            next_tbtt    <= '0;
            tbtt_count   <= '0;
            tbtt_aligned <= 1'b0;
            tbtt_missed  <= 1'b0;
            tbtt_pulse   <= 1'b0;
            mod_start    <= 1'b0;
            mod_abort    <= 1'b0;
        end else begin
            tbtt_pulse <= 1'b0;
            mod_start  <= 1'b0;
            mod_abort  <= 1'b0;
            if (!run_ok) begin
                if (state != IDLE) mod_abort <= 1'b1;
                state        <= IDLE;
                tbtt_aligned <= 1'b0;
            end else if (align_entry) begin
                state        <= ALIGN;
                bi_lat       <= beacon_interval_tu;
                tsf_snap     <= tsf_runtime_val;
                mod_start    <= 1'b1;
                tbtt_aligned <= 1'b0;
                if (tbtt_resync) tbtt_missed <= 1'b0;
                else if (state == WAIT) tbtt_missed <= 1'b1;
            end else begin
                unique case (state)
                    ALIGN: begin
                        // A done still in flight from an aborted run is ignored.
                        if (mod_done && !mod_start) begin
                            next_tbtt    <= aligned_next;
                            tbtt_count   <= '0;
                            tbtt_aligned <= 1'b1;
                            state        <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (tsf_pulse_1M && hit) begin
                            tbtt_pulse <= 1'b1;
                            next_tbtt  <= next_plus;
                            tbtt_count <= tbtt_count + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef TBTT_PRE_WARN_EN
    logic                   pre_done;
    logic                   wait_ok;
    logic                   pre_fire;
    logic [TIMER_WIDTH-1:0] lead;

    assign lead     = tsf_runtime_val + TIMER_WIDTH'(pre_tbtt_us);
    assign wait_ok  = run_ok && !tbtt_resync && wait_tick && !jump;
    assign pre_fire = wait_ok && !hit && (lead >= next_tbtt) && !pre_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_done       <= 1'b0;
            pre_tbtt_pulse <= 1'b0;
        end else begin
            pre_tbtt_pulse <= 1'b0;
            if (align_entry || (wait_ok && hit)) begin
                pre_done <= 1'b0;
            end else if (pre_fire) begin
                pre_done       <= 1'b1;
                pre_tbtt_pulse <= 1'b1;
            end
        end
    end
`else
    logic unused_pre;
    assign unused_pre     = ^pre_tbtt_us;
    assign pre_tbtt_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_tbtt_scheduler.sv
// Scoreboard bench for tbtt_scheduler with a grid-arithmetic reference model.
module tb_tbtt_scheduler;

    localparam int TW      = 64;
    localparam int BW      = 16;
    localparam int PW      = 16;
    localparam int LATENCY = 56;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [TW-1:0] tsf_runtime_val = '0;
    logic          tsf_pulse_1M = 1'b0;
    logic [BW-1:0] beacon_interval_tu = '0;
    logic [PW-1:0] pre_tbtt_us = '0;
    logic          tbtt_resync = 1'b0;
    logic          tbtt_pulse;
    logic          pre_tbtt_pulse;
    logic [TW-1:0] next_tbtt;
    logic [15:0]   tbtt_count;
    logic          tbtt_aligned;
    logic          tbtt_missed;

    typedef struct {
        bit              is_tbtt;
        longint unsigned tsf;
        int              count;
        longint unsigned nxt;
    } ev_t;

    ev_t             exp_q[$];
    ev_t             mon_e;
    longint unsigned last_tick = 0;
    int              n_cmp = 0;
    int              n_bad = 0;

    always #5 clk = ~clk;

    tbtt_scheduler #(
        .TIMER_WIDTH (TW),
        .BI_WIDTH    (BW),
        .PRE_WIDTH   (PW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .tsf_runtime_val    (tsf_runtime_val),
        .tsf_pulse_1M       (tsf_pulse_1M),
        .beacon_interval_tu (beacon_interval_tu),
        .pre_tbtt_us        (pre_tbtt_us),
        .tbtt_resync        (tbtt_resync),
        .tbtt_pulse         (tbtt_pulse),
        .pre_tbtt_pulse     (pre_tbtt_pulse),
        .next_tbtt          (next_tbtt),
        .tbtt_count         (tbtt_count),
        .tbtt_aligned       (tbtt_aligned),
        .tbtt_missed        (tbtt_missed)
    );

    function automatic void check(string name, longint unsigned act,
                                  longint unsigned req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // TBTTs are the multiples of the interval strictly above the snapshot.
    function automatic void plan(longint unsigned s, int b, int pre,
                                 longint unsigned e);
        longint unsigned bu = longint'(b) * 1024;
        longint unsigned t  = (s / bu + 1) * bu;
        longint unsigned pe = 0;
        int              k  = 0;
`ifdef TBTT_PRE_WARN_EN
        pe = longint'(pre);
`endif
        while (t - pe <= e) begin
            if (pe > 0) exp_q.push_back('{1'b0, t - pe, 0, 64'd0});
            if (t <= e) begin
                k++;
                exp_q.push_back('{1'b1, t, k, t + bu});
            end
            t += bu;
        end
    endfunction

    always @(posedge clk) begin
        if (tsf_pulse_1M) last_tick <= tsf_runtime_val;
    end

    always @(negedge clk) begin
        if (!rst && (tbtt_pulse || pre_tbtt_pulse)) begin
            check("pulse overlap", 64'(tbtt_pulse & pre_tbtt_pulse), 0);
            if (exp_q.size() == 0) begin
                check("unexpected pulse", 64'({tbtt_pulse, pre_tbtt_pulse}), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse kind", 64'(tbtt_pulse), 64'(mon_e.is_tbtt));
                check("pulse tsf", last_tick, mon_e.tsf);
                if (mon_e.is_tbtt) begin
                    check("tbtt_count", 64'(tbtt_count), 64'(mon_e.count));
                    check("next after pulse", next_tbtt, mon_e.nxt);
                end
            end
        end
    end

    task automatic run_until(longint unsigned e);
        while (tsf_runtime_val < e) begin
            @(posedge clk);
            #1;
            tsf_pulse_1M = 1'b0;
            if ($urandom_range(0, 2) != 0) begin
                tsf_runtime_val = tsf_runtime_val + 1;
                tsf_pulse_1M    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        tsf_pulse_1M = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // First edge is the ALIGN entry edge; TSF ticks slowly meanwhile.
    task automatic wait_aligned(string name, longint unsigned exp_next);
        int c    = 0;
        bit seen = 1'b0;
        while (c < 80 && !seen) begin
            @(posedge clk);
            #1;
            c++;
            tbtt_resync  = 1'b0;
            tsf_pulse_1M = 1'b0;
            if (tbtt_aligned) begin
                seen = 1'b1;
            end else if (c % 4 == 0) begin
                tsf_runtime_val = tsf_runtime_val + 1;
                tsf_pulse_1M    = 1'b1;
            end
        end
        check({name, " latency"}, 64'(c - 1), LATENCY);
        check({name, " next_tbtt"}, next_tbtt, exp_next);
    endtask

    task automatic check_zero(string tag);
        check({tag, " tbtt_pulse"}, 64'(tbtt_pulse), 0);
        check({tag, " pre_tbtt_pulse"}, 64'(pre_tbtt_pulse), 0);
        check({tag, " next_tbtt"}, next_tbtt, 0);
        check({tag, " tbtt_count"}, 64'(tbtt_count), 0);
        check({tag, " tbtt_aligned"}, 64'(tbtt_aligned), 0);
        check({tag, " tbtt_missed"}, 64'(tbtt_missed), 0);
    endtask

    initial begin
        longint unsigned s;
        longint unsigned bu;
        longint unsigned t0;
        longint unsigned e;
        int              b;
        int              p;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("reset");

        tsf_runtime_val    = 5000;
        beacon_interval_tu = 1;
        pre_tbtt_us        = 100;
        plan(5000, 1, 100, 6200);
        enable = 1'b1;
        wait_aligned("align 5000", 5120);
        run_until(6200);
        check("drain 5000", 64'(exp_q.size()), 0);
        check("missed before jump", 64'(tbtt_missed), 0);

        plan(100000, 1, 100, 101500);
        tsf_runtime_val = 100000;
        tsf_pulse_1M    = 1'b1;
        wait_aligned("align jump", 100352);
        check("missed after jump", 64'(tbtt_missed), 1);
        run_until(100600);
        beacon_interval_tu = 3;
        run_until(101500);
        check("drain jump", 64'(exp_q.size()), 0);

        plan(101500, 3, 100, 107600);
        tbtt_resync = 1'b1;
        wait_aligned("align resync", 104448);
        check("missed after resync", 64'(tbtt_missed), 0);
        run_until(107600);
        check("drain resync", 64'(exp_q.size()), 0);

        enable = 1'b0;
        @(posedge clk);
        #1;
        check("disable aligned", 64'(tbtt_aligned), 0);
        check("disable next kept", next_tbtt, 110592);
        run_until(110700);
        check("idle next kept", next_tbtt, 110592);

        tsf_runtime_val    = 4096;
        beacon_interval_tu = 2;
        plan(4096, 2, 100, 8300);
        enable = 1'b1;
        wait_aligned("align 4096", 6144);
        run_until(8300);
        check("drain 4096", 64'(exp_q.size()), 0);

        for (int i = 0; i < 3; i++) begin
            enable = 1'b0;
            @(posedge clk);
            #1;
            b  = $urandom_range(1, 2);
            p  = $urandom_range(0, 400);
            bu = longint'(b) * 1024;
            s  = ({$urandom, $urandom} & 64'h0000_FFFF_FFFF_FFFF)
               | 64'h0000_0100_0000_0000;
            if (bu - (s % bu) < longint'(p + 24)) s = s - longint'(p + 24);
            t0 = (s / bu + 1) * bu;
            e  = t0 + bu + 50;
            tsf_runtime_val    = s;
            beacon_interval_tu = BW'(b);
            pre_tbtt_us        = PW'(p);
            plan(s, b, p, e);
            enable = 1'b1;
            wait_aligned("align random", t0);
            run_until(e);
            check("drain random", 64'(exp_q.size()), 0);
        end

        enable = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async reset");
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check_zero("after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tbtt_scheduler.md
# tbtt_scheduler

Target Beacon Transmission Time (TBTT) scheduler that sits directly downstream of the TSF timer. It consumes the 64-bit TSF value and its 1 µs tick and aligns to the 802.11 beacon grid (TBTT ≡ 0 mod beacon interval). It emits a one-cycle TBTT pulse, an optional early-warning pulse and the next TBTT value. The beacon TX path and the xpu slot logic use these outputs. It re-aligns itself when the TSF is reloaded or jumps.

## Interface
Parameters:
- TIMER_WIDTH, 64, TSF width; must match the TSF timer.
- BI_WIDTH, 16, width of the beacon interval in TU.
- PRE_WIDTH, 16, width of the pre-TBTT lead time in µs.

Ports:
- clk  in  1  single clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; 0 forces IDLE.
- tsf_runtime_val  in  TIMER_WIDTH  current TSF in µs.
- tsf_pulse_1M  in  1  high on the cycle tsf_runtime_val has just incremented.
- beacon_interval_tu  in  BI_WIDTH  beacon interval; 1 TU = 1024 µs; 0 = disabled.
- pre_tbtt_us  in  PRE_WIDTH  lead time of pre_tbtt_pulse.
- tbtt_resync  in  1  one-cycle request to re-align, e.g. after a TSF load.
- tbtt_pulse  out  1  one cycle per TBTT.
- pre_tbtt_pulse  out  1  one cycle per period, ahead of the TBTT.
- next_tbtt  out  TIMER_WIDTH  TSF of the upcoming TBTT.
- tbtt_count  out  16  TBTTs since alignment; wraps.
- tbtt_aligned  out  1  high while in WAIT.
- tbtt_missed  out  1  sticky; set on a detected TSF jump; cleared by tbtt_resync or rst.

## Operation
- States: IDLE, ALIGN, WAIT.
- IDLE -> ALIGN when enable=1 and beacon_interval_tu≠0.
- On ALIGN entry:
  - latch bi_lat = beacon_interval_tu;
  - latch tsf_snap = tsf_runtime_val;
  - start the mod unit.
- Interval arithmetic:
  - BI_us = bi_lat << 10.
  - tsf mod BI_us = (((tsf_snap >> 10) mod bi_lat) << 10) | tsf_snap[9:0].
- ALIGN result: next_tbtt = tsf_snap − mod + BI_us, then -> WAIT and tbtt_count cleared.
- An exactly aligned snapshot (mod = 0) gives next_tbtt = tsf_snap + BI_us.
- WAIT is evaluated only on cycles where tsf_pulse_1M=1.
  - If tsf ≥ next_tbtt + BI_us (forward jump) or next_tbtt − tsf > BI_us (backward jump): set tbtt_missed, no pulse, -> ALIGN.
  - Else if tsf ≥ next_tbtt: tbtt_pulse=1, next_tbtt += BI_us, tbtt_count++, clear pre_done.
  - Else if tsf + pre_tbtt_us ≥ next_tbtt and !pre_done: pre_tbtt_pulse=1, set pre_done.
- tbtt_resync in any state with enable=1 and BI≠0 -> ALIGN, abort/restart the mod unit, clear tbtt_missed.
- enable=0 or beacon_interval_tu=0 from any state -> IDLE on the next edge:
  - mod unit aborted;
  - tbtt_aligned=0;
  - next_tbtt retained.
- beacon_interval_tu changes are ignored until the next ALIGN entry.
- All additions are modulo 2^TIMER_WIDTH; TSF wrap is not handled specially.

## Timing
- Reset values: all outputs 0, state IDLE, pre_done 0.
- ALIGN latency is fixed at 56 cycles from the ALIGN entry edge to tbtt_aligned=1:
  - 1 load cycle;
  - 54 restoring-division iterations (dividend TIMER_WIDTH−10 bits);
  - 1 finalize cycle.
- tbtt_pulse and pre_tbtt_pulse are registered: asserted the cycle after the tsf_pulse_1M cycle that qualifies them, for exactly one cycle.
- If TBTT and pre-TBTT qualify on the same tick (pre_tbtt_us ≥ remaining time at alignment), only tbtt_pulse fires for that period.
- tbtt_resync coincident with a qualifying tick: resync wins; no pulse.
- rst asserted mid-ALIGN or mid-WAIT takes effect immediately (asynchronous); release is synchronous to clk.

## Configuration
- TBTT_PRE_WARN_EN defined: pre-TBTT comparator and pre_done flag are built as described.
- TBTT_PRE_WARN_EN undefined:
  - pre_tbtt_pulse tied 0;
  - pre_tbtt_us ignored;
  - no comparator or flag logic.

## Structure
- Shared package tsf_pkg holds:
  - TU_SHIFT = 10;
  - the state encoding (IDLE/ALIGN/WAIT);
  - ALIGN_LATENCY = 56.
- Sub-module tbtt_mod_calc: sequential restoring divider with start/abort/done handshake.
  - Inputs: dividend of TIMER_WIDTH−10 bits, divisor of BI_WIDTH bits.
  - Output: remainder.
  - Busy exactly 55 cycles.

## Test plan
- Reset, enable=1, BI=1 (1024 µs), TSF ticking from 5000 -> tbtt_aligned after 56 cycles; next_tbtt=5120; tbtt_pulse at TSF 5120, then 6144; tbtt_count 1, 2.
- BI=1, pre_tbtt_us=100, TSF from 5000 -> pre_tbtt_pulse at TSF 5020 and 6044, each exactly once per period; with the macro undefined, none.
- Snapshot TSF=4096, BI=2 -> next_tbtt=6144 (aligned case); pulse at 6144, then 8192.
- In WAIT, the TSF timer loads 100000 -> tbtt_missed=1, re-ALIGN, next_tbtt=100352; tbtt_resync clears tbtt_missed.
- BI changed from 1 to 3 mid-WAIT -> old 1024 µs spacing continues; after tbtt_resync, spacing is 3072 µs.
- Assert rst during ALIGN cycle 30, and separately drop enable mid-WAIT -> all outputs reach reset values or tbtt_aligned=0 respectively, with no stray pulses.
